// File: rtl/mine_game_pkg.sv
// Shared types and constants for the minesweeper game sequencer.
// FSM state codes, move directions, board geometry and the LED encoding of the state.
package mine_game_pkg;

  localparam int CELLS = 64;
  localparam int IDX_W = 6;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE  = 4'd0;
  localparam state_t S_CLEAR = 4'd1;
  localparam state_t S_FIRST = 4'd2;
  localparam state_t S_GEN   = 4'd3;
  localparam state_t S_LOAD  = 4'd4;
  localparam state_t S_STEP  = 4'd5;
  localparam state_t S_DRAW  = 4'd6;
  localparam state_t S_PLAY  = 4'd7;
  localparam state_t S_WON   = 4'd8;
  localparam state_t S_LOST  = 4'd9;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  typedef enum logic [1:0] {EV_NONE, EV_STEP, EV_FLAG, EV_MOVE} ev_t;

  // LEDs: {game over, lost or pre-play (FIRST..STEP), sequencer busy}
  function automatic logic [2:0] state_leds(input state_t s);
    logic over;
    logic lost_pre;
    logic busy;
    over     = (s == S_WON) || (s == S_LOST);
    lost_pre = (s == S_LOST) || (s == S_FIRST) || (s == S_GEN) ||
               (s == S_LOAD) || (s == S_STEP);
    busy     = (s == S_CLEAR) || (s == S_GEN) || (s == S_LOAD) ||
               (s == S_STEP) || (s == S_DRAW);
    return {over, lost_pre, busy};
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser plus registered rising-edge detect for one raw button.
// Latency 3 cycles from raw edge to a one-cycle evt_o pulse; no backpressure.
module btn_edge (
  input  logic clk,
  input  logic resetn,
  input  logic btn_i,
  output logic evt_o
);

  logic s1_q, s2_q, s3_q, evt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      evt_q <= s2_q & ~s3_q;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/mine_game_ctrl.sv
// Game sequencer: button events to datapath load pulses, mine generation, redraw handshake, win/lose.
// Pulses are one cycle, combinational from state and registered events; DRAW stalls until draw_ack.
module mine_game_ctrl
  import mine_game_pkg::*;
#(
  parameter int NUM_MINES = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             btn_step,
  input  logic             btn_flag,
  input  logic             btn_move,
  input  logic [1:0]       move_dir,
  input  logic [IDX_W-1:0] pos_idx,
  input  logic [IDX_W-1:0] rnd,
  input  logic             win,
  input  logic             lose,
  input  logic             draw_ack,
  output logic             lfsr_en,
  output logic             ld_mm,
  output logic [CELLS-1:0] mm_in,
  output logic             ld_fm,
  output logic             ld_sm,
  output logic             mv,
  output logic [1:0]       dir,
  output logic             draw_req,
  output logic [2:0]       state_o
);

  localparam logic [IDX_W-1:0] MINES_TGT = IDX_W'(NUM_MINES);

  logic start_evt, step_evt, flag_evt, move_evt;

  btn_edge u_start (.clk(clk), .resetn(resetn), .btn_i(start),    .evt_o(start_evt));
  btn_edge u_step  (.clk(clk), .resetn(resetn), .btn_i(btn_step), .evt_o(step_evt));
  btn_edge u_flag  (.clk(clk), .resetn(resetn), .btn_i(btn_flag), .evt_o(flag_evt));
  btn_edge u_move  (.clk(clk), .resetn(resetn), .btn_i(btn_move), .evt_o(move_evt));

  state_t           st_q, st_d, ret_q, ret_d;
  logic             chk_q, chk_d;
  logic [CELLS-1:0] acc_q, acc_d, mm_q, mm_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  ev_t              ev;

  // start wins outright; only one lower-priority event survives per cycle
  always_comb begin
    ev = EV_NONE;
    if (!start_evt) begin
      if (step_evt)      ev = EV_STEP;
      else if (flag_evt) ev = EV_FLAG;
      else if (move_evt) ev = EV_MOVE;
    end
  end

  always_comb begin
    st_d     = st_q;
    ret_d    = ret_q;
    chk_d    = 1'b0;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mm_d     = mm_q;
    mm_in    = mm_q;
    ld_mm    = 1'b0;
    ld_fm    = 1'b0;
    ld_sm    = 1'b0;
    mv       = 1'b0;
    dir      = 2'd0;
    lfsr_en  = 1'b0;
    draw_req = 1'b0;
    case (st_q)
      S_IDLE, S_WON, S_LOST: ;
      S_CLEAR: begin
        ld_mm = 1'b1;
        mm_in = '0;
        mm_d  = '0;
        acc_d = '0;
        cnt_d = '0;
        st_d  = S_FIRST;
      end
      S_FIRST: begin
        if (ev == EV_STEP) begin
          st_d = S_GEN;
        end else if (ev == EV_MOVE) begin
          mv    = 1'b1;
          dir   = move_dir;
          ret_d = S_FIRST;
          st_d  = S_DRAW;
        end
      end
      S_GEN: begin
        lfsr_en = 1'b1;
        // the first stepped cell and already-placed cells are never accepted
        if (rnd != pos_idx && !acc_q[rnd]) begin
          acc_d[rnd] = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_d == MINES_TGT) st_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ld_mm = 1'b1;
        mm_in = acc_q;
        mm_d  = acc_q;
        st_d  = S_STEP;
      end
      S_STEP: begin
        ld_sm = 1'b1;
        ret_d = S_PLAY;
        st_d  = S_DRAW;
      end
      S_DRAW: begin
        draw_req = !start_evt;
        if (draw_ack) begin
          st_d  = ret_q;
          chk_d = (ret_q == S_PLAY);
        end
      end
      S_PLAY: begin
        if (chk_q && lose) begin
          st_d = S_LOST;
        end else if (chk_q && win) begin
          st_d = S_WON;
        end else if (ev != EV_NONE) begin
          ld_sm = (ev == EV_STEP);
          ld_fm = (ev == EV_FLAG);
          mv    = (ev == EV_MOVE);
          dir   = (ev == EV_MOVE) ? move_dir : 2'd0;
          ret_d = S_PLAY;
          st_d  = S_DRAW;
        end
      end
      default: st_d = S_IDLE;
    endcase
    if (start_evt && st_q != S_CLEAR) st_d = S_CLEAR;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q  <= S_IDLE;
      ret_q <= S_IDLE;
      chk_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      mm_q  <= '0;
    end else begin
      st_q  <= st_d;
      ret_q <= ret_d;
      chk_q <= chk_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      mm_q  <= mm_d;
    end
  end

  assign state_o = state_leds(st_q);

endmodule

// File: tb/tb_mine_game_ctrl.sv
// Bench for mine_game_ctrl: pulse scoreboard, PLAY action table, hand-written game sequences.
module tb_mine_game_ctrl;
  import mine_game_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, start, btn_step, btn_flag, btn_move;
  logic [1:0]  move_dir;
  logic [5:0]  pos_idx, rnd;
  logic        win, lose, draw_ack;
  logic        lfsr_en, ld_mm, ld_fm, ld_sm, mv, draw_req;
  logic [63:0] mm_in;
  logic [1:0]  dir;
  logic [2:0]  state_o;

  mine_game_ctrl #(.NUM_MINES(2)) dut (
    .clk(clk), .resetn(resetn), .start(start), .btn_step(btn_step),
    .btn_flag(btn_flag), .btn_move(btn_move), .move_dir(move_dir),
    .pos_idx(pos_idx), .rnd(rnd), .win(win), .lose(lose), .draw_ack(draw_ack),
    .lfsr_en(lfsr_en), .ld_mm(ld_mm), .mm_in(mm_in), .ld_fm(ld_fm), .ld_sm(ld_sm),
    .mv(mv), .dir(dir), .draw_req(draw_req), .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] L_IDLE = 3'b000, L_FIRST = 3'b010, L_GEN = 3'b011,
                         L_DRAW = 3'b001, L_PLAY = 3'b000, L_WON = 3'b100, L_LOST = 3'b110;

  typedef struct packed {
    logic        ld_mm;
    logic [63:0] mm;
    logic        ld_fm;
    logic        ld_sm;
    logic        mv;
    logic [1:0]  dir;
  } obs_t;

  typedef struct {
    logic [2:0] btn;   // {step, flag, move}
    logic [1:0] mdir;
    logic       fm;
    logic       sm;
    logic       mvx;
    logic [1:0] d;
  } vec_t;

  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         gen_cycles = 0;
  int         ldmm_cyc = 0;
  int         ldsm_cyc = 0;
  obs_t       expq[$];
  logic [5:0] rq[$];
  string      tname = "reset";
  vec_t       vt[7];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic obs_t mk(input logic m, input logic [63:0] map, input logic fm,
                              input logic sm, input logic mvv, input logic [1:0] d);
    obs_t o;
    o.ld_mm = m; o.mm = map; o.ld_fm = fm; o.ld_sm = sm; o.mv = mvv; o.dir = d;
    return o;
  endfunction

  task automatic press(input logic [3:0] m);
    @(posedge clk); #1;
    {start, btn_step, btn_flag, btn_move} = m;
    repeat (5) @(posedge clk); #1;
    {start, btn_step, btn_flag, btn_move} = 4'b0;
    repeat (6) @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // LFSR model: one queued value per GEN cycle, last value held when empty
  initial forever begin
    @(posedge clk); #1;
    if (lfsr_en) begin
      gen_cycles++;
      if (rq.size() > 0) rnd = rq.pop_front();
    end
  end

  // every load/move pulse must match the next expected scoreboard entry
  initial forever begin
    obs_t o, e;
    @(negedge clk);
    if (resetn && (ld_mm || ld_fm || ld_sm || mv)) begin
      o = mk(ld_mm, ld_mm ? mm_in : 64'd0, ld_fm, ld_sm, mv, dir);
      if (ld_mm) ldmm_cyc = cyc;
      if (ld_sm) ldsm_cyc = cyc;
      if (expq.size() == 0) begin
        check($sformatf("unexpected_pulse@%s", tname), 128'(o), 128'(0));
      end else begin
        e = expq.pop_front();
        check($sformatf("pulse@%s", tname), 128'(o), 128'(e));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0] = '{3'b010, DIR_RIGHT, 1'b1, 1'b0, 1'b0, 2'd0};
    vt[1] = '{3'b011, DIR_UP,    1'b1, 1'b0, 1'b0, 2'd0};
    vt[2] = '{3'b100, DIR_RIGHT, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[3] = '{3'b001, DIR_RIGHT, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[4] = '{3'b001, DIR_UP,    1'b0, 1'b0, 1'b1, 2'd3};
    vt[5] = '{3'b111, DIR_LEFT,  1'b0, 1'b1, 1'b0, 2'd0};
    vt[6] = '{3'b001, DIR_LEFT,  1'b0, 1'b0, 1'b1, 2'd1};

    resetn = 1'b0; start = 1'b0; btn_step = 1'b0; btn_flag = 1'b0; btn_move = 1'b0;
    move_dir = 2'd0; pos_idx = 6'd27; rnd = 6'd0; win = 1'b0; lose = 1'b0; draw_ack = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("reset_pulses", {ld_mm, ld_fm, ld_sm, mv, dir, draw_req, lfsr_en}, 0);
    check("reset_mm_in", mm_in, 0);
    check("reset_state", state_o, L_IDLE);
    resetn = 1'b1;

    tname = "start";
    expq.push_back(mk(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    press(4'b1000);
    check("start_state", state_o, L_FIRST);

    tname = "first_move";
    move_dir = DIR_LEFT;
    expq.push_back(mk(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 2'd1));
    press(4'b0001);
    check("first_move_state", state_o, L_FIRST);
    tname = "first_flag";
    press(4'b0010);
    check("first_flag_state", state_o, L_FIRST);

    tname = "gen";
    rq = '{6'd27, 6'd27, 6'd3, 6'd3, 6'd5};
    gen_cycles = 0;
    expq.push_back(mk(1'b1, 64'h28, 1'b0, 1'b0, 1'b0, 2'd0));
    expq.push_back(mk(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 2'd0));
    press(4'b0100);
    repeat (4) @(posedge clk); #1;
    check("gen_cycles", gen_cycles, 5);
    check("ldsm_after_ldmm", ldsm_cyc - ldmm_cyc, 1);
    check("gen_play_state", state_o, L_PLAY);
    check("gen_mm_in_held", mm_in, 64'h28);

    for (int i = 0; i < 7; i++) begin
      tname = $sformatf("table%0d", i);
      move_dir = vt[i].mdir;
      expq.push_back(mk(1'b0, 64'd0, vt[i].fm, vt[i].sm, vt[i].mvx, vt[i].d));
      press({1'b0, vt[i].btn});
      check($sformatf("table%0d_state", i), state_o, L_PLAY);
    end

    tname = "slow_draw";
    draw_ack = 1'b0;
    move_dir = DIR_DOWN;
    expq.push_back(mk(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 2'd2));
    @(posedge clk); #1;
    btn_move = 1'b1;
    for (int i = 0; i < 20 && !draw_req; i++) @(negedge clk);
    check("draw_req_rise", draw_req, 1'b1);
    btn_move = 1'b0;
    btn_step = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(draw_req);
    end
    check("draw_req_held", n, 20);
    check("draw_state", state_o, L_DRAW);
    draw_ack = 1'b1;
    btn_step = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("after_draw_state", state_o, L_PLAY);
    check("after_draw_req", draw_req, 1'b0);

    tname = "lose";
    win = 1'b1; lose = 1'b1;
    expq.push_back(mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 2'd0));
    press(4'b0010);
    check("lost_state", state_o, L_LOST);
    win = 1'b0; lose = 1'b0;
    tname = "restart_lost";
    expq.push_back(mk(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    press(4'b1000);
    check("restart_lost_state", state_o, L_FIRST);

    tname = "won";
    win = 1'b1;
    rq = '{6'd1, 6'd2};
    expq.push_back(mk(1'b1, 64'h6, 1'b0, 1'b0, 1'b0, 2'd0));
    expq.push_back(mk(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 2'd0));
    press(4'b0100);
    check("won_state", state_o, L_WON);
    win = 1'b0;
    tname = "restart_won";
    expq.push_back(mk(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    press(4'b1000);
    check("restart_won_state", state_o, L_FIRST);

    tname = "reset_mid_gen";
    rq = '{6'd3, 6'd27};
    @(posedge clk); #1;
    btn_step = 1'b1;
    for (int i = 0; i < 20 && !lfsr_en; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("mid_gen_state", state_o, L_GEN);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_gen_reset_pulses", {ld_mm, ld_fm, ld_sm, mv, dir, draw_req, lfsr_en}, 0);
    check("mid_gen_reset_mm_in", mm_in, 0);
    check("mid_gen_reset_state", state_o, L_IDLE);
    btn_step = 1'b0;
    repeat (3) @(posedge clk); #1;
    resetn = 1'b1;

    tname = "post_reset_game";
    expq.push_back(mk(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 2'd0));
    press(4'b1000);
    rq = '{6'd5, 6'd9};
    expq.push_back(mk(1'b1, 64'h220, 1'b0, 1'b0, 1'b0, 2'd0));
    expq.push_back(mk(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 2'd0));
    press(4'b0100);
    repeat (4) @(posedge clk); #1;
    check("post_reset_state", state_o, L_PLAY);

    check("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mine_game_ctrl.md
Name: mine_game_ctrl

Overview:
- Top-level game sequencer for the 8x8 minesweeper datapath; sits between the board keys/switches and the datapath load strobes.
- Debounce-free edge detection of player buttons; generates the mine map from an external LFSR after the first step, so the first stepped cell is always safe.
- Issues single-cycle load pulses (mine/flag/step/move) to the datapath; handshakes every board change with the VGA gameboard renderer; tracks win/lose.

Parameters:
- NUM_MINES, 10, mines placed per game; legal range 1..63.
- CELLS, 64, board cells (fixed 8x8); index width 6.

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- start  in  1  raw new-game request, level, active high
- btn_step  in  1  raw step button, active high
- btn_flag  in  1  raw flag button, active high
- btn_move  in  1  raw move button, active high
- move_dir  in  2  direction with btn_move: 0 right, 1 left, 2 down, 3 up
- pos_idx  in  6  current cursor cell index from datapath
- rnd  in  6  low bits of LFSR output
- win  in  1  datapath win flag
- lose  in  1  datapath lose flag
- draw_ack  in  1  renderer finished redraw
- lfsr_en  out  1  advance LFSR
- ld_mm  out  1  load mine map pulse
- mm_in  out  64  mine map value for ld_mm
- ld_fm  out  1  toggle-flag pulse
- ld_sm  out  1  step pulse
- mv  out  1  move pulse
- dir  out  2  direction valid with mv, else 0
- draw_req  out  1  redraw request
- state_o  out  3  FSM state encoding for LEDs

Behaviour:
- Reset (async, resetn=0): state IDLE; all pulse outputs, draw_req, lfsr_en = 0; mm_in = 0; mine accumulator and count = 0; synchronisers and edge registers = 0.
- Inputs start/btn_* pass through 2-flop synchronisers; an event is a synced 0->1 edge (latency 3 cycles from raw edge to event).
- Same-cycle events priority: start > step > flag > move; lower ones are dropped. Events arriving in states other than those consuming them are dropped, never queued.
- States: IDLE, CLEAR, FIRST, GEN, LOAD, STEP, DRAW, PLAY, WON, LOST (encodings 0..9 truncated: state_o = {WON|LOST, LOST|STEP-phase, busy}; exact map in package).
- IDLE/WON/LOST: start event -> CLEAR.
- CLEAR: one cycle, ld_mm=1 with mm_in=0; accumulator and count cleared -> FIRST.
- FIRST: move event -> mv=1, dir=move_dir for one cycle -> DRAW (return to FIRST). Flag events ignored. Step event -> GEN.
- GEN: lfsr_en=1 every cycle; rnd sampled same cycle; accept if rnd != pos_idx and accumulator[rnd]=0: set bit, count+1. When count reaches NUM_MINES (after that accept) -> LOAD; lfsr_en drops on exit.
- LOAD: one cycle, ld_mm=1, mm_in=accumulator -> STEP.
- STEP: one cycle, ld_sm=1 -> DRAW (return to PLAY).
- PLAY: step -> ld_sm pulse; flag -> ld_fm pulse; move -> mv/dir pulse; each then -> DRAW.
- DRAW: draw_req=1 from entry until draw_ack sampled high; then return state. draw_ack outside DRAW ignored. On exit to PLAY, win/lose evaluated the following cycle: lose -> LOST (lose beats win), else win -> WON, else stay PLAY.
- start event in any in-game state (FIRST..PLAY, including mid-GEN or mid-DRAW) aborts -> CLEAR; draw_req drops immediately.
- mm_in holds last loaded value between ld_mm pulses.

Decomposition:
- Package mine_game_pkg: state enum, direction constants, CELLS, index width, state_o encoding.
- Sub-module btn_edge (2-flop sync + rising-edge detect), instantiated once per button and for start.

Test Plan:
- Reset then start, draw_ack tied high -> ld_mm pulse with mm_in=0, state FIRST, no other pulses.
- In FIRST, pos_idx=27, step; rnd sequence 27,27,3,3,5,... NUM_MINES=2 -> 27 and repeat 3 rejected; mm_in has bits 3 and 5 only, then ld_mm, then ld_sm one cycle later.
- PLAY, btn_flag and btn_move same raw edge -> only ld_fm pulses; mv stays 0.
- PLAY, move dir=2, draw_ack held low 20 cycles -> mv=1 dir=2 for one cycle, draw_req high 20 cycles, step pressed meanwhile ignored.
- After redraw, win=1 and lose=1 -> LOST; start -> CLEAR, ld_mm with mm_in=0.
- resetn asserted mid-GEN -> outputs zero immediately, state IDLE, accumulator cleared.
